ula_issue_ctrl: RTL and testbench

//  Issue side of the ALU interface: accepts one MIPS instruction plus register operands, decodes it,

---
 rtl/ula_pkg.sv | 73 +++++++
 rtl/ula_issue_ctrl_if.sv | 36 +++
 rtl/ula_decode.sv | 93 +++++++++
 rtl/ula_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_ula_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared constants for the ALU issue controller: ALU OP codes, MIPS
// opcode/funct values, FSM state encoding and the decoded-instruction record.
// Optional feature macro: ULA_ITYPE_EN (enables addi/slti/sltiu/andi/ori/xori).
package ula_pkg;

  localparam int ULA_DW = 32;
  localparam int ULA_RW = 5;

  // ALU operation codes
  localparam logic [3:0] OP_SLL  = 4'h0;
  localparam logic [3:0] OP_SRL  = 4'h1;
  localparam logic [3:0] OP_SRA  = 4'h2;
  localparam logic [3:0] OP_SLLV = 4'h3;
  localparam logic [3:0] OP_SRLV = 4'h4;
  localparam logic [3:0] OP_SRAV = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_SLT  = 4'hC;
  localparam logic [3:0] OP_SLTU = 4'hD;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // Decoded instruction: ALU control plus write-back attributes
  typedef struct packed {
    logic [3:0]        op;
    logic [4:0]        shamt;      // fixed shift amount (0 for variable shifts)
    logic              sel_shift;  // In1 = rt
    logic              sel_var;    // In2 = rs (variable shift)
    logic              sel_imm;    // In2 = extended immediate
    logic [ULA_RW-1:0] dest;
    logic              branch;
    logic              bne;        // branch taken on !Zero
    logic              illegal;
    logic              we;
  } dec_t;

endpackage

// File: rtl/ula_issue_ctrl_if.sv
// Instruction-in / write-back-record-out bundle of the ALU issue controller.
// Both sides use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; the source holds valid and its payload stable
// until that edge, and ready may depend combinationally on the sink's state.
interface ula_issue_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_dest;
  logic          res_we;
  logic          res_branch;
  logic          res_taken;
  logic          res_illegal;

  // Issue controller side
  modport slave (
    input  instr_valid, instr, rs_data, rt_data, res_ready,
    output instr_ready, res_valid, res_data, res_dest, res_we,
           res_branch, res_taken, res_illegal
  );

  // Register-read / write-back side
  modport master (
    output instr_valid, instr, rs_data, rt_data, res_ready,
    input  instr_ready, res_valid, res_data, res_dest, res_we,
           res_branch, res_taken, res_illegal
  );
endinterface

// File: rtl/ula_decode.sv
// Combinational MIPS decoder for the ALU issue controller.
// Input word is the instruction with the rs index field removed
// ({opcode, rt, imm16}); register values arrive separately.
// Optional feature macro: ULA_ITYPE_EN (I-type ALU instructions).
module ula_decode
  import ula_pkg::*;
#(
  parameter int DW = ULA_DW
) (
  input  logic [26:0]   word_i,
  output dec_t          dec_o,
  output logic [DW-1:0] imm_o
);

  logic [5:0]        opcode;
  logic [ULA_RW-1:0] rt_idx;
  logic [ULA_RW-1:0] rd_idx;
  logic [4:0]        shamt_f;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic              imm_sext;

  assign opcode  = word_i[26:21];
  assign rt_idx  = word_i[20:16];
  assign imm16   = word_i[15:0];
  assign rd_idx  = word_i[15:11];
  assign shamt_f = word_i[10:6];
  assign funct   = word_i[5:0];

  // Opcode/funct to ALU control and record attributes
  always_comb begin
    dec_o    = '0;
    imm_sext = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_SLL:  begin dec_o.op = OP_SLL;  dec_o.sel_shift = 1'b1; end
          FN_SRL:  begin dec_o.op = OP_SRL;  dec_o.sel_shift = 1'b1; end
          FN_SRA:  begin dec_o.op = OP_SRA;  dec_o.sel_shift = 1'b1; end
          FN_SLLV: begin dec_o.op = OP_SLLV; dec_o.sel_shift = 1'b1; dec_o.sel_var = 1'b1; end
          FN_SRLV: begin dec_o.op = OP_SRLV; dec_o.sel_shift = 1'b1; dec_o.sel_var = 1'b1; end
          FN_SRAV: begin dec_o.op = OP_SRAV; dec_o.sel_shift = 1'b1; dec_o.sel_var = 1'b1; end
          FN_ADD:  dec_o.op = OP_ADD;
          FN_SUB:  dec_o.op = OP_SUB;
          FN_AND:  dec_o.op = OP_AND;
          FN_OR:   dec_o.op = OP_OR;
          FN_XOR:  dec_o.op = OP_XOR;
          FN_NOR:  dec_o.op = OP_NOR;
          FN_SLT:  dec_o.op = OP_SLT;
          FN_SLTU: dec_o.op = OP_SLTU;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OPC_BEQ: begin dec_o.op = OP_SUB; dec_o.branch = 1'b1; end
      OPC_BNE: begin dec_o.op = OP_SUB; dec_o.branch = 1'b1; dec_o.bne = 1'b1; end
`ifdef ULA_ITYPE_EN
      OPC_ADDI:  begin dec_o.op = OP_ADD;  dec_o.sel_imm = 1'b1; imm_sext = 1'b1; end
      OPC_SLTI:  begin dec_o.op = OP_SLT;  dec_o.sel_imm = 1'b1; imm_sext = 1'b1; end
      OPC_SLTIU: begin dec_o.op = OP_SLTU; dec_o.sel_imm = 1'b1; imm_sext = 1'b1; end
      OPC_ANDI:  begin dec_o.op = OP_AND;  dec_o.sel_imm = 1'b1; end
      OPC_ORI:   begin dec_o.op = OP_OR;   dec_o.sel_imm = 1'b1; end
      OPC_XORI:  begin dec_o.op = OP_XOR;  dec_o.sel_imm = 1'b1; end
`endif
      default: dec_o.illegal = 1'b1;
    endcase

    // Only the three fixed shifts take the amount from the instruction
    if (dec_o.sel_shift && !dec_o.sel_var) dec_o.shamt = shamt_f;

    // Branches have no destination; I-type writes rt, R-type writes rd
    if (opcode == OPC_RTYPE)   dec_o.dest = rd_idx;
    else if (dec_o.sel_imm)    dec_o.dest = rt_idx;

    // Undecodable words drive a quiet ALU (OP 0, zero inputs)
    if (dec_o.illegal) begin
      dec_o.op        = 4'h0;
      dec_o.shamt     = 5'd0;
      dec_o.sel_shift = 1'b0;
      dec_o.sel_var   = 1'b0;
      dec_o.sel_imm   = 1'b0;
      dec_o.dest      = '0;
    end

    // Register 0 is never written
    dec_o.we = !dec_o.illegal && !dec_o.branch && (dec_o.dest != '0);
  end

  // Immediate extension: arithmetic/compare sign-extend, logical zero-extend
  always_comb begin
    imm_o = imm_sext ? {{(DW-16){imm16[15]}}, imm16} : {{(DW-16){1'b0}}, imm16};
  end

endmodule

// File: rtl/ula_issue_ctrl.sv
// ALU issue controller: accepts an instruction with its register operands,
// decodes it, drives registered ALU inputs, captures the ALU result and Zero
// flag, and offers a write-back/branch record. FSM IDLE->DECODE->EXEC->WB;
// a new instruction may be accepted on the edge that hands off a record.
// Optional feature macro: ULA_ITYPE_EN (I-type ALU instructions).
module ula_issue_ctrl
  import ula_pkg::*;
#(
  parameter int DW = ULA_DW,
  parameter int RW = ULA_RW
) (
  input  logic           clk,
  input  logic           rst_n,
  ula_issue_if.slave     bus,
  output logic [DW-1:0]  alu_in1_o,
  output logic [DW-1:0]  alu_in2_o,
  output logic [3:0]     alu_op_o,
  output logic [4:0]     alu_shamt_o,
  input  logic [DW-1:0]  alu_result_i,
  input  logic           alu_zero_i,
  output state_e         state_o
);

  state_e        state_q, state_d;
  logic          instr_ready;
  logic          res_valid;
  logic          accept;

  logic [26:0]   instr_q;
  logic [DW-1:0] rs_q, rt_q;

  dec_t          dec;
  logic [DW-1:0] imm_ext;

  logic [DW-1:0] alu_in1_q, alu_in1_d;
  logic [DW-1:0] alu_in2_q, alu_in2_d;
  logic [3:0]    alu_op_q;
  logic [4:0]    alu_shamt_q;

  logic [DW-1:0] res_data_q;
  logic [RW-1:0] res_dest_q;
  logic          res_we_q, res_branch_q, res_taken_q, res_illegal_q;

  // The rs index field is not needed; operands arrive as values
  ula_decode #(.DW(DW)) u_decode (
    .word_i (instr_q),
    .dec_o  (dec),
    .imm_o  (imm_ext)
  );

  // Next state, ready and valid from the current state and handshakes
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          instr_ready = 1'b1;
          state_d     = bus.instr_valid ? ST_DECODE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = bus.instr_valid && instr_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latch instruction and operands on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else if (accept) begin
      instr_q <= {bus.instr[31:26], bus.instr[20:0]};
      rs_q    <= bus.rs_data;
      rt_q    <= bus.rt_data;
    end
  end

  // Operand routing: shifts take the value from rt, variable shifts the amount from rs
  always_comb begin
    alu_in1_d = rs_q;
    alu_in2_d = rt_q;
    if (dec.sel_shift) begin
      alu_in1_d = rt_q;
      alu_in2_d = dec.sel_var ? rs_q : '0;
    end
    if (dec.sel_imm) alu_in2_d = imm_ext;
    if (dec.illegal) begin
      alu_in1_d = '0;
      alu_in2_d = '0;
    end
  end

  // ALU drive registers, loaded at the end of DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_op_q    <= '0;
      alu_shamt_q <= '0;
    end else if (state_q == ST_DECODE) begin
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_op_q    <= dec.op;
      alu_shamt_q <= dec.shamt;
    end
  end

  // Result record, captured at the end of EXEC and held through WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q    <= '0;
      res_dest_q    <= '0;
      res_we_q      <= 1'b0;
      res_branch_q  <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      res_data_q    <= alu_result_i;
      res_dest_q    <= RW'(dec.dest);
      res_we_q      <= dec.we;
      res_branch_q  <= dec.branch;
      res_taken_q   <= dec.branch && (dec.bne ? !alu_zero_i : alu_zero_i);
      res_illegal_q <= dec.illegal;
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.res_valid   = res_valid;
  assign bus.res_data    = res_data_q;
  assign bus.res_dest    = res_dest_q;
  assign bus.res_we      = res_we_q;
  assign bus.res_branch  = res_branch_q;
  assign bus.res_taken   = res_taken_q;
  assign bus.res_illegal = res_illegal_q;

  assign alu_in1_o   = alu_in1_q;
  assign alu_in2_o   = alu_in2_q;
  assign alu_op_o    = alu_op_q;
  assign alu_shamt_o = alu_shamt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// Directed bench for ula_issue_ctrl with a behavioural ALU attached.
module tb_ula_issue_ctrl;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic        alu_zero;
  state_e      state;

  int errors = 0;
  int checks = 0;

  ula_issue_if #(.DW(32), .RW(5)) bus ();

  ula_issue_ctrl #(.DW(32), .RW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_in1_o    (alu_in1),
    .alu_in2_o    (alu_in2),
    .alu_op_o     (alu_op),
    .alu_shamt_o  (alu_shamt),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero),
    .state_o      (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  always_comb begin
    case (alu_op)
      4'h0: alu_result = alu_in1 << alu_shamt;
      4'h1: alu_result = alu_in1 >> alu_shamt;
      4'h2: alu_result = $unsigned($signed(alu_in1) >>> alu_shamt);
      4'h3: alu_result = alu_in1 << alu_in2[4:0];
      4'h4: alu_result = alu_in1 >> alu_in2[4:0];
      4'h5: alu_result = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
      4'h6: alu_result = alu_in1 + alu_in2;
      4'h7: alu_result = alu_in1 - alu_in2;
      4'h8: alu_result = alu_in1 & alu_in2;
      4'h9: alu_result = alu_in1 | alu_in2;
      4'hA: alu_result = alu_in1 ^ alu_in2;
      4'hB: alu_result = ~(alu_in1 | alu_in2);
      4'hC: alu_result = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      4'hD: alu_result = {31'd0, alu_in1 < alu_in2};
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // ---------------- driver tasks ----------------
  // Present an instruction and hold it until accepted; returns at the
  // falling edge after the accepting edge (DUT then in DECODE).
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, output bit ok);
    int n = 0;
    @(negedge clk);
    bus.instr       = ins;
    bus.rs_data     = rs;
    bus.rt_data     = rt;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.instr_ready;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!bus.res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = bus.res_valid;
  endtask

  // Take the record offered at the current falling edge
  task automatic consume();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready: got %b want 1", bus.instr_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    checks++; if ({alu_in1, alu_in2, alu_op, alu_shamt} !== 73'd0) begin errors++; $display("FAIL reset_alu: got %h want 0", {alu_in1, alu_in2, alu_op, alu_shamt}); end
    checks++; if ({bus.res_data, bus.res_dest, bus.res_we, bus.res_branch, bus.res_taken, bus.res_illegal} !== 41'd0) begin errors++; $display("FAIL reset_record: got %h want 0", {bus.res_data, bus.res_dest}); end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
  endtask

  task automatic test_add();
    bit ok;
    send(rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD), 32'd5, 32'd7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_accept: got 0 want 1"); end
    checks++; if (bus.res_valid !== 1'b0 || state !== ST_DECODE) begin errors++; $display("FAIL add_lat1: got valid=%b st=%0d want 0/1", bus.res_valid, state); end
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b0 || state !== ST_EXEC) begin errors++; $display("FAIL add_lat2: got valid=%b st=%0d want 0/2", bus.res_valid, state); end
    checks++; if ({alu_op, alu_in1, alu_in2} !== {4'h6, 32'd5, 32'd7}) begin errors++; $display("FAIL add_alu: got op=%h in1=%h in2=%h want 6/5/7", alu_op, alu_in1, alu_in2); end
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL add_lat3: got valid=%b want 1", bus.res_valid); end
    checks++; if (bus.res_data !== 32'd12) begin errors++; $display("FAIL add_data: got %h want %h", bus.res_data, 32'd12); end
    checks++; if ({bus.res_dest, bus.res_we, bus.res_branch, bus.res_illegal} !== {5'd3, 3'b100}) begin errors++; $display("FAIL add_attr: got dest=%0d we=%b br=%b ill=%b want 3/1/0/0", bus.res_dest, bus.res_we, bus.res_branch, bus.res_illegal); end
    consume();
    checks++; if (state !== ST_IDLE || bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_idle: got st=%0d valid=%b want 0/0", state, bus.res_valid); end
    // rd = 0: value reported, no write
    send(rtype(5'd1, 5'd2, 5'd0, 5'd0, FN_ADD), 32'd5, 32'd7, ok);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd0_timeout: got 0 want 1"); end
    checks++; if ({bus.res_data, bus.res_we} !== {32'd12, 1'b0}) begin errors++; $display("FAIL rd0: got data=%h we=%b want c/0", bus.res_data, bus.res_we); end
    consume();
    // carry discarded
    send(rtype(5'd1, 5'd2, 5'd4, 5'd0, FN_ADD), 32'hFFFF_FFFF, 32'd2, ok);
    wait_valid(ok);
    checks++; if (bus.res_data !== 32'd1) begin errors++; $display("FAIL add_wrap: got %h want 1", bus.res_data); end
    consume();
  endtask

  task automatic test_shift();
    bit ok;
    send(rtype(5'd0, 5'd2, 5'd4, 5'd4, FN_SRA), 32'h1234_5678, 32'h8000_0000, ok);
    @(negedge clk);
    checks++; if ({alu_op, alu_shamt, alu_in1} !== {4'h2, 5'd4, 32'h8000_0000}) begin errors++; $display("FAIL sra_alu: got op=%h sh=%0d in1=%h want 2/4/80000000", alu_op, alu_shamt, alu_in1); end
    wait_valid(ok);
    checks++; if (bus.res_data !== 32'hF800_0000) begin errors++; $display("FAIL sra_data: got %h want f8000000", bus.res_data); end
    consume();
    send(rtype(5'd1, 5'd2, 5'd5, 5'd9, FN_SLLV), 32'd4, 32'd1, ok);
    @(negedge clk);
    checks++; if ({alu_op, alu_shamt, alu_in1, alu_in2} !== {4'h3, 5'd0, 32'd1, 32'd4}) begin errors++; $display("FAIL sllv_alu: got op=%h sh=%0d in1=%h in2=%h want 3/0/1/4", alu_op, alu_shamt, alu_in1, alu_in2); end
    wait_valid(ok);
    checks++; if (bus.res_data !== 32'd16) begin errors++; $display("FAIL sllv_data: got %h want 10", bus.res_data); end
    consume();
  endtask

  task automatic test_branch();
    bit ok;
    send(itype(OPC_BEQ, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9, ok);
    wait_valid(ok);
    checks++; if ({bus.res_branch, bus.res_taken, bus.res_we} !== 3'b110) begin errors++; $display("FAIL beq_eq: got br=%b tk=%b we=%b want 1/1/0", bus.res_branch, bus.res_taken, bus.res_we); end
    consume();
    send(itype(OPC_BNE, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9, ok);
    wait_valid(ok);
    checks++; if ({bus.res_branch, bus.res_taken, bus.res_we} !== 3'b100) begin errors++; $display("FAIL bne_eq: got br=%b tk=%b we=%b want 1/0/0", bus.res_branch, bus.res_taken, bus.res_we); end
    consume();
    send(itype(OPC_BNE, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd3, ok);
    wait_valid(ok);
    checks++; if ({bus.res_branch, bus.res_taken} !== 2'b11) begin errors++; $display("FAIL bne_ne: got br=%b tk=%b want 1/1", bus.res_branch, bus.res_taken); end
    consume();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit stable = 1'b1;
    send(rtype(5'd1, 5'd2, 5'd5, 5'd0, FN_ADD), 32'd1, 32'd2, ok);
    wait_valid(ok);
    for (int i = 0; i < 5; i++) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd3 || bus.res_dest !== 5'd5 || bus.instr_ready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_hold: got unstable record or ready, want held"); end
    bus.instr       = rtype(5'd1, 5'd2, 5'd6, 5'd0, FN_SUB);
    bus.rs_data     = 32'd10;
    bus.rt_data     = 32'd3;
    bus.instr_valid = 1'b1;
    bus.res_ready   = 1'b1;
    #1;
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b want 1", bus.instr_ready); end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.res_ready   = 1'b0;
    checks++; if (state !== ST_DECODE || bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_decode: got st=%0d valid=%b want 1/0", state, bus.res_valid); end
    @(negedge clk);
    @(negedge clk);
    checks++; if ({bus.res_valid, bus.res_data, bus.res_dest} !== {1'b1, 32'd7, 5'd6}) begin errors++; $display("FAIL b2b_rec: got v=%b d=%h dst=%0d want 1/7/6", bus.res_valid, bus.res_data, bus.res_dest); end
    consume();
  endtask

  task automatic test_illegal();
    bit ok;
    send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'd5, 32'd7, ok);
    @(negedge clk);
    checks++; if ({alu_op, alu_in1, alu_in2} !== 68'd0) begin errors++; $display("FAIL ill_alu: got op=%h in1=%h in2=%h want 0", alu_op, alu_in1, alu_in2); end
    wait_valid(ok);
    checks++; if ({bus.res_illegal, bus.res_we} !== 2'b10) begin errors++; $display("FAIL ill_rec: got ill=%b we=%b want 1/0", bus.res_illegal, bus.res_we); end
    consume();
    send(itype(OPC_ORI, 5'd1, 5'd7, 16'h000F), 32'h0000_00F0, 32'h1234, ok);
    wait_valid(ok);
`ifdef ULA_ITYPE_EN
    checks++; if ({bus.res_data, bus.res_dest, bus.res_we, bus.res_illegal} !== {32'hFF, 5'd7, 2'b10}) begin errors++; $display("FAIL ori: got d=%h dst=%0d we=%b ill=%b want ff/7/1/0", bus.res_data, bus.res_dest, bus.res_we, bus.res_illegal); end
`else
    checks++; if ({bus.res_illegal, bus.res_we} !== 2'b10) begin errors++; $display("FAIL ori_ill: got ill=%b we=%b want 1/0", bus.res_illegal, bus.res_we); end
`endif
    consume();
  endtask

  task automatic test_reset_exec();
    bit ok;
    bit quiet = 1'b1;
    send(rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD), 32'd5, 32'd7, ok);
    @(negedge clk);
    checks++; if (state !== ST_EXEC) begin errors++; $display("FAIL rst_pre: got st=%0d want 2", state); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.instr_ready, bus.res_valid, state} !== {2'b10, 2'd0}) begin errors++; $display("FAIL rst_ctl: got rdy=%b v=%b st=%0d want 1/0/0", bus.instr_ready, bus.res_valid, state); end
    checks++; if ({alu_in1, alu_in2, alu_op, bus.res_data, bus.res_we} !== 101'd0) begin errors++; $display("FAIL rst_data: got in1=%h data=%h want 0", alu_in1, bus.res_data); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL rst_drop: got res_valid=1 want 0"); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.rs_data     = '0;
    bus.rt_data     = '0;
    bus.res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_add();
    test_shift();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
